seg7_scan_controller: RTL and testbench

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

---
 rtl/seg7_scan_controller.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with a
// double-buffered digit register that is swapped only at frame boundaries.
//
// Ports:
//   CLK, RST_N    clock, asynchronous active-low reset
//   enable        1 = scan display, 0 = dark and halted
//   load          strobe capturing digits_in / dp_in into the shadow register
//   digits_in     four hex nibbles, digit0 = [3:0]
//   dp_in         decimal point per digit, 1 = lit
//   an            anode enables, active-low
//   seg           segments {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low
//   load_ack      pulse when shadow moves to the active register
//   frame_start   pulse on the first cycle of the digit0 slot
module seg7_scan_controller #(
    parameter int DIV_COUNT    = 47999,
    parameter int BLANK_CYCLES = 480
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        load_ack,
    output logic        frame_start
);

    localparam int DW = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV_COUNT);
    localparam logic [15:0]   BLANK_LAST = 16'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    idx_q;
    logic [DW-1:0] div_q;
    logic [15:0]   blank_q;
    logic [15:0]   active_q;
    logic [15:0]   shadow_q;
    logic [3:0]    adp_q;
    logic [3:0]    sdp_q;
    logic          pending_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          load_ack_q;
    logic          frame_start_q;

    logic          tick;
    logic          blank_done;
    logic          frame_wrap;
    logic          idle_go;
    logic          xfer;
    logic [15:0]   active_d;
    logic [3:0]    adp_d;
    logic          pending_d;
    logic [1:0]    idx_d;
    logic [3:0]    nib_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_comb begin
        tick       = (state_q == SHOW) && (div_q == DIV_LAST);
        blank_done = (state_q == BLANK) && (blank_q == BLANK_LAST);
        frame_wrap = enable && blank_done && (idx_q == 2'd3);
        idle_go    = enable && (state_q == IDLE);
        // IDLE drains a pending shadow at once; while scanning, only the
        // frame boundary may swap, so a digit never changes mid-frame.
        xfer       = pending_q && ((state_q == IDLE) || frame_wrap);
        active_d   = xfer ? shadow_q : active_q;
        adp_d      = xfer ? sdp_q : adp_q;
        // A load in the swap cycle keeps the new data pending.
        pending_d  = load | (pending_q & ~xfer);
        // Slot index used only when entering SHOW.
        idx_d      = (state_q == BLANK) ? idx_q + 2'd1 : 2'd0;
        nib_d      = active_d[{idx_d, 2'b00} +: 4];
        seg_d      = hex7(nib_d);
        dp_d       = adp_d[idx_d];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            div_q         <= '0;
            blank_q       <= 16'd0;
            active_q      <= 16'd0;
            shadow_q      <= 16'd0;
            adp_q         <= 4'd0;
            sdp_q         <= 4'd0;
            pending_q     <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            adp_q         <= adp_d;
            pending_q     <= pending_d;
            load_ack_q    <= xfer;
            frame_start_q <= idle_go || frame_wrap;
            if (load) begin
                shadow_q <= digits_in;
                sdp_q    <= dp_in;
            end
            if (!enable) begin
                state_q <= IDLE;
                idx_q   <= 2'd0;
                div_q   <= '0;
                blank_q <= 16'd0;
                an_q    <= 4'hF;
                seg_q   <= 7'h7F;
                dp_q    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SHOW;
                        idx_q   <= idx_d;
                        div_q   <= '0;
                        blank_q <= 16'd0;
                        an_q    <= ~(4'b0001 << idx_d);
                        seg_q   <= seg_d;
                        dp_q    <= ~dp_d;
                    end
                    SHOW: begin
                        if (tick) begin
                            state_q <= BLANK;
                            div_q   <= '0;
                            blank_q <= 16'd0;
                            an_q    <= 4'hF;
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                    BLANK: begin
                        if (blank_done) begin
                            state_q <= SHOW;
                            idx_q   <= idx_d;
                            div_q   <= '0;
                            blank_q <= 16'd0;
                            an_q    <= ~(4'b0001 << idx_d);
                            seg_q   <= seg_d;
                            dp_q    <= ~dp_d;
                        end else begin
                            blank_q <= blank_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= 2'd0;
                        div_q   <= '0;
                        blank_q <= 16'd0;
                        an_q    <= 4'hF;
                        seg_q   <= 7'h7F;
                        dp_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Testbench for seg7_scan_controller: frame-position reference model
// with randomized load/enable traffic and directed boundary scenarios.
module tb_seg7_scan_controller;

    localparam int DIVC  = 9;
    localparam int BLK   = 2;
    localparam int SHOWN = DIVC + 1;
    localparam int SLOT  = SHOWN + BLK;
    localparam int FRAME = 4 * SLOT;
    localparam logic [111:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    logic        CLK;
    logic        RST_N;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        load_ack;
    logic        frame_start;
    logic [13:0] obs;

    int n_assert = 0;
    int n_fail   = 0;

    bit          m_run;
    int          m_pos;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_sdp;
    bit          m_pend;
    logic        m_la, m_fs;
    logic [13:0] exp_vec;

    seg7_scan_controller #(
        .DIV_COUNT    (DIVC),
        .BLANK_CYCLES (BLK)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .enable      (enable),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .load_ack    (load_ack),
        .frame_start (frame_start)
    );

    assign obs = {an, seg, dp, load_ack, frame_start};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [13:0] model_out();
        int slot, w;
        logic [3:0] nib, a;
        if (!m_run) return {4'hF, 7'h7F, 1'b1, m_la, m_fs};
        slot = m_pos / SLOT;
        w    = m_pos % SLOT;
        nib  = 4'((m_act >> (4 * slot)) & 16'hF);
        a    = (w < SHOWN) ? 4'(~(4'b0001 << slot)) : 4'hF;
        return {a, GLYPHS[nib*7 +: 7], ~m_adp[slot[1:0]], m_la, m_fs};
    endfunction

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_act = '0; m_sh = '0;
        m_adp = '0; m_sdp = '0; m_pend = 0; m_la = 0; m_fs = 0;
        exp_vec = model_out();
    endtask

    task automatic step(input logic en, input logic ld,
                        input logic [15:0] d, input logic [3:0] p);
        logic x;
        enable = en; load = ld; digits_in = d; dp_in = p;
        @(posedge CLK);
        x = 0; m_fs = 0;
        if (!m_run) begin
            x = m_pend;
            if (en) begin m_run = 1; m_pos = 0; m_fs = 1; end
        end else if (!en) begin
            m_run = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) begin m_fs = 1; x = m_pend; end
        end
        m_la = x;
        if (x) begin m_act = m_sh; m_adp = m_sdp; m_pend = 0; end
        if (ld) begin m_sh = d; m_sdp = p; m_pend = 1; end
        exp_vec = model_out();
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 0; enable = 0; load = 0; digits_in = '0; dp_in = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_assert++;
        if (obs !== 14'h3FFC) begin
            n_fail++;
            $display("FAIL reset_out got %b expected %b", obs, 14'h3FFC);
        end
        RST_N = 1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, '0);
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL idle_dark got %b expected %b", obs, exp_vec);
            end
        end
    endtask

    task automatic test_scan_default();
        int nfs = 0;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            step(1, 0, '0, '0);
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL scan i=%0d got %b expected %b", i, obs, exp_vec);
            end
            n_assert++;
            if (seg !== 7'b1000000) begin
                n_fail++;
                $display("FAIL scan_zero i=%0d got %b expected 1000000", i, seg);
            end
            if (frame_start) nfs++;
        end
        n_assert++;
        if (nfs !== 3) begin
            n_fail++;
            $display("FAIL scan_frames got %0d expected 3", nfs);
        end
    endtask

    task automatic test_idle_load();
        logic [6:0] want [4];
        int nla = 0;
        want = '{7'b0001110, 7'b1111000, 7'b0001000, 7'b0110000};
        step(0, 0, '0, '0);
        step(0, 1, 16'h3A7F, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, '0);
            if (load_ack) nla++;
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL idle_load got %b expected %b", obs, exp_vec);
            end
        end
        n_assert++;
        if (nla !== 1) begin
            n_fail++;
            $display("FAIL idle_ack got %0d pulses expected 1", nla);
        end
        for (int i = 0; i < FRAME + 2; i++) begin
            step(1, 0, '0, '0);
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL idle_show got %b expected %b", obs, exp_vec);
            end
            if (m_pos % SLOT < SHOWN) begin
                n_assert++;
                if (seg !== want[m_pos / SLOT] ||
                    dp !== (m_pos / SLOT != 2)) begin
                    n_fail++;
                    $display("FAIL glyph pos=%0d got %b/%b expected %b",
                             m_pos, seg, dp, want[m_pos / SLOT]);
                end
            end
        end
    endtask

    task automatic test_midframe_loads();
        int nla = 0, n2 = 0;
        for (int k = 0; k < 100 && m_pos != 5; k++) step(1, 0, '0, '0);
        step(1, 1, 16'h1111, 4'b0000);
        step(1, 0, '0, '0);
        step(1, 1, 16'h2222, 4'b0000);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1, 0, '0, '0);
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL midframe got %b expected %b", obs, exp_vec);
            end
            if (load_ack) begin
                nla++;
                n_assert++;
                if (frame_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ack_align got fs=%b expected 1", frame_start);
                end
            end
            if (nla == 1 && an !== 4'hF && seg === 7'b0100100) n2++;
        end
        n_assert++;
        if (nla !== 1) begin
            n_fail++;
            $display("FAIL mid_acks got %0d expected 1", nla);
        end
        n_assert++;
        if (n2 < 4 * SHOWN) begin
            n_fail++;
            $display("FAIL mid_2222 got %0d lit cycles expected >= %0d", n2, 4 * SHOWN);
        end
    endtask

    task automatic test_boundary_load();
        int k;
        for (k = 0; k < 300 && !(m_run && m_pos == FRAME - 1 && !m_pend); k++)
            step(1, 0, '0, '0);
        n_assert++;
        if (!(m_run && m_pos == FRAME - 1 && !m_pend)) begin
            n_fail++;
            $display("FAIL bnd_reach got pos=%0d expected %0d", m_pos, FRAME - 1);
        end
        step(1, 1, 16'h5A5A, 4'b1001);
        n_assert++;
        if (frame_start !== 1'b1 || load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_first got fs=%b ack=%b expected fs=1 ack=0",
                     frame_start, load_ack);
        end
        step(1, 0, '0, '0);
        for (k = 0; k < 2 * FRAME && !frame_start; k++) begin
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL bnd_run got %b expected %b", obs, exp_vec);
            end
            step(1, 0, '0, '0);
        end
        n_assert++;
        if (frame_start !== 1'b1 || load_ack !== 1'b1 || obs !== exp_vec) begin
            n_fail++;
            $display("FAIL bnd_next got fs=%b ack=%b expected fs=1 ack=1",
                     frame_start, load_ack);
        end
    endtask

    task automatic test_disable_blank();
        for (int k = 0; k < 200 && m_pos != SLOT + SHOWN; k++) step(1, 0, '0, '0);
        n_assert++;
        if (an !== 4'hF || m_pos != SLOT + SHOWN) begin
            n_fail++;
            $display("FAIL dis_blank got an=%b expected 1111", an);
        end
        step(0, 0, '0, '0);
        n_assert++;
        if (an !== 4'hF || obs !== exp_vec) begin
            n_fail++;
            $display("FAIL dis_dark got %b expected %b", obs, exp_vec);
        end
        step(1, 0, '0, '0);
        n_assert++;
        if (frame_start !== 1'b1 || an !== 4'b1110 || obs !== exp_vec) begin
            n_fail++;
            $display("FAIL dis_restart got %b expected %b", obs, exp_vec);
        end
    endtask

    task automatic test_random();
        logic en, ld;
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 99) < 97);
            ld = ($urandom_range(0, 99) < 4);
            step(en, ld, 16'($urandom), 4'($urandom));
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL random i=%0d got %b expected %b", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        for (int k = 0; k < 200 && !(m_run && m_pos % SLOT == 3); k++)
            step(1, 0, '0, '0);
        step(1, 1, 16'hBEEF, 4'b1111);
        #2;
        RST_N = 0;
        #1;
        n_assert++;
        if (obs !== 14'h3FFC) begin
            n_fail++;
            $display("FAIL async_rst got %b expected %b", obs, 14'h3FFC);
        end
        model_reset();
        enable = 0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1;
        for (int i = 0; i < FRAME + 4; i++) begin
            step(1, 0, '0, '0);
            n_assert++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL post_rst got %b expected %b", obs, exp_vec);
            end
            if (load_ack !== 1'b0 || seg !== 7'b1000000) bad++;
        end
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_lost got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_scan_default();
        test_idle_load();
        test_midframe_loads();
        test_boundary_load();
        test_disable_blank();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
